// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR command sequencer: command encodings,
// sequencer state type, tap mask and the LFSR next-state function.
package lfsr_pkg;

   localparam int unsigned LFSR_W = 8;
   localparam int unsigned OP_W   = 2;
   localparam int unsigned CNT_W  = 8;

   // Feedback taps at bits 0, 2, 3 and 4.
   localparam logic [LFSR_W-1:0] TAP_MASK = 8'b0001_1101;

   typedef enum logic [OP_W-1:0] {
      OP_LOAD = 2'd0,
      OP_STEP = 2'd1,
      OP_RUN  = 2'd2,
      OP_STOP = 2'd3
   } cmd_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BURST = 2'd1,
      ST_RUN   = 2'd2
   } state_e;

   // Command payload as seen by the sequencer.
   typedef struct packed {
      cmd_op_e             op;
      logic [LFSR_W-1:0]   arg;
   } cmd_t;

   // Fibonacci shift: feedback enters at the MSB.
   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
      return {^(q & TAP_MASK), q[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// 8-bit Fibonacci LFSR register.
// Ports: clk, rst (async active-low), load/load_val (parallel load, wins over
// step), step (advance one state), q (current state).
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter logic [LFSR_W-1:0] RESET_SEED = 8'h01
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [LFSR_W-1:0] load_val,
   input  logic              step,
   output logic [LFSR_W-1:0] q
);

   // State register; load has priority over step.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= RESET_SEED;
      end else if (load) begin
         q <= load_val;
      end else if (step) begin
         q <= lfsr_next(q);
      end
   end

endmodule

// File: rtl/lfsr_seq.sv
// Command-driven LFSR sequencer: LOAD / STEP-N / RUN / STOP over valid/ready,
// steps paced by a DIV-clock prescaler, zero seeds rejected.
// Ports: clk, rst (async active-low); cmd_valid/cmd_op/cmd_arg/cmd_ready
// command handshake; lfsr_q current state; step_o new-state pulse; done_o
// burst/stop completion pulse; busy_o stepping active; seed_err sticky
// zero-seed flag; cmd_err ignored-command pulse.
module lfsr_seq
   import lfsr_pkg::*;
#(
   parameter int unsigned       DIV        = 4,
   parameter logic [LFSR_W-1:0] RESET_SEED = 8'h01
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   input  logic [OP_W-1:0]   cmd_op,
   input  logic [LFSR_W-1:0] cmd_arg,
   output logic              cmd_ready,
   output logic [LFSR_W-1:0] lfsr_q,
   output logic              step_o,
   output logic              done_o,
   output logic              busy_o,
   output logic              seed_err,
   output logic              cmd_err
);

   localparam logic [CNT_W-1:0] PS_LAST = CNT_W'(DIV - 1);

   state_e            state_q, state_n;
   logic [CNT_W-1:0]  ps_q, ps_n;
   logic [CNT_W-1:0]  rem_q, rem_n;
   cmd_t              cmd_c;
   logic              accept_c;
   logic              stop_c;
   logic              tick_c;
   logic              load_c;
   logic              step_c;
   logic              done_c;
   logic              cerr_c;
   logic              serr_set_c;
   logic              serr_clr_c;

   // Always ready outside reset; every state accepts a command.
   assign cmd_ready = rst;

   assign cmd_c    = '{op: cmd_op_e'(cmd_op), arg: cmd_arg};
   assign accept_c = cmd_valid & cmd_ready;
   assign stop_c   = accept_c && (cmd_c.op == OP_STOP);
   assign tick_c   = (state_q != ST_IDLE) && (ps_q == PS_LAST);

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   // Next-state logic.
   always_comb begin
      state_n = state_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               if (cmd_c.op == OP_STEP && cmd_c.arg != '0) begin
                  state_n = ST_BURST;
               end else if (cmd_c.op == OP_RUN) begin
                  state_n = ST_RUN;
               end
            end
         end
         ST_BURST: begin
            if (stop_c) begin
               state_n = ST_IDLE;
            end else if (tick_c && rem_q == CNT_W'(1)) begin
               state_n = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (stop_c) begin
               state_n = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Datapath controls and pulse sources.
   always_comb begin
      ps_n       = ps_q;
      rem_n      = rem_q;
      load_c     = 1'b0;
      step_c     = 1'b0;
      done_c     = 1'b0;
      cerr_c     = 1'b0;
      serr_set_c = 1'b0;
      serr_clr_c = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Prescaler parked at 0 so entry to BURST/RUN starts a full period.
            ps_n = '0;
            if (accept_c) begin
               case (cmd_c.op)
                  OP_LOAD: begin
                     if (cmd_c.arg != '0) begin
                        load_c     = 1'b1;
                        serr_clr_c = 1'b1;
                     end else begin
                        serr_set_c = 1'b1;
                     end
                  end
                  OP_STEP: begin
                     if (cmd_c.arg != '0) begin
                        rem_n = cmd_c.arg;
                     end else begin
                        done_c = 1'b1;
                     end
                  end
                  OP_STOP: done_c = 1'b1;
                  default: ;
               endcase
            end
         end
         ST_BURST, ST_RUN: begin
            if (stop_c) begin
               // STOP beats a coincident tick.
               done_c = 1'b1;
               rem_n  = '0;
               ps_n   = '0;
            end else begin
               cerr_c = accept_c;
               if (tick_c) begin
                  step_c = 1'b1;
                  ps_n   = '0;
                  if (state_q == ST_BURST) begin
                     rem_n  = rem_q - CNT_W'(1);
                     done_c = (rem_q == CNT_W'(1));
                  end
               end else begin
                  ps_n = ps_q + CNT_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   // Counters, flags and registered pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ps_q     <= '0;
         rem_q    <= '0;
         step_o   <= 1'b0;
         done_o   <= 1'b0;
         busy_o   <= 1'b0;
         seed_err <= 1'b0;
         cmd_err  <= 1'b0;
      end else begin
         ps_q    <= ps_n;
         rem_q   <= rem_n;
         step_o  <= step_c;
         done_o  <= done_c;
         busy_o  <= (state_n != ST_IDLE);
         cmd_err <= cerr_c;
         if (serr_set_c) begin
            seed_err <= 1'b1;
         end else if (serr_clr_c) begin
            seed_err <= 1'b0;
         end
      end
   end

   lfsr_core #(
      .RESET_SEED (RESET_SEED)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (load_c),
      .load_val (cmd_c.arg),
      .step     (step_c),
      .q        (lfsr_q)
   );

endmodule

// File: tb/tb_lfsr_seq.sv
// Bench for lfsr_seq: instance 0 with DIV=1, instance 1 with DIV=4, checked
// against a cycle-count model of the command rules.
module tb_lfsr_seq;

   logic       clk;
   logic       rst;
   logic       cv   [2];
   logic [1:0] cop  [2];
   logic [7:0] carg [2];
   logic       crdy [2];
   logic [7:0] q    [2];
   logic       stp  [2];
   logic       dn   [2];
   logic       bsy  [2];
   logic       serr [2];
   logic       cerr [2];

   logic [7:0] mq    [2];
   logic       mserr [2];

   int total = 0;
   int bad   = 0;

   lfsr_seq #(.DIV(1), .RESET_SEED(8'h01)) dut_a (
      .clk(clk), .rst(rst), .cmd_valid(cv[0]), .cmd_op(cop[0]), .cmd_arg(carg[0]),
      .cmd_ready(crdy[0]), .lfsr_q(q[0]), .step_o(stp[0]), .done_o(dn[0]),
      .busy_o(bsy[0]), .seed_err(serr[0]), .cmd_err(cerr[0]));

   lfsr_seq #(.DIV(4), .RESET_SEED(8'h01)) dut_b (
      .clk(clk), .rst(rst), .cmd_valid(cv[1]), .cmd_op(cop[1]), .cmd_arg(carg[1]),
      .cmd_ready(crdy[1]), .lfsr_q(q[1]), .step_o(stp[1]), .done_o(dn[1]),
      .busy_o(bsy[1]), .seed_err(serr[1]), .cmd_err(cerr[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] nxt(input logic [7:0] v);
      return {v[0] ^ v[2] ^ v[3] ^ v[4], v[7:1]};
   endfunction

   function automatic int div_of(input int d);
      return (d == 0) ? 1 : 4;
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_load(input int d, input logic [7:0] arg);
      cv[d] = 1'b1; cop[d] = 2'd0; carg[d] = arg;
      cyc();
      cv[d] = 1'b0;
      if (arg != 8'h00) begin
         mq[d] = arg;
         mserr[d] = 1'b0;
      end else begin
         mserr[d] = 1'b1;
      end
      total++;
      if (q[d] !== mq[d]) begin
         bad++; $display("FAIL load_q d=%0d arg=%h got=%h exp=%h", d, arg, q[d], mq[d]);
      end
      total++;
      if (serr[d] !== mserr[d]) begin
         bad++; $display("FAIL load_seed_err d=%0d arg=%h got=%b exp=%b", d, arg, serr[d], mserr[d]);
      end
      total++;
      if (stp[d] !== 1'b0 || cerr[d] !== 1'b0 || bsy[d] !== 1'b0) begin
         bad++; $display("FAIL load_pulses d=%0d step=%b cmd_err=%b busy=%b exp=000", d, stp[d], cerr[d], bsy[d]);
      end
   endtask

   // STEP n; inj>0 issues LOAD 8'h33 in burst cycle inj (must be ignored).
   task automatic do_burst(input int d, input int n, input int inj);
      int  dv, last, steps;
      bit  es, ed, ee;
      dv = div_of(d);
      last = dv * n + 1;
      steps = 0;
      cv[d] = 1'b1; cop[d] = 2'd1; carg[d] = 8'(n);
      total++;
      if (crdy[d] !== 1'b1) begin
         bad++; $display("FAIL step_ready d=%0d got=%b exp=1", d, crdy[d]);
      end
      cyc();
      cv[d] = 1'b0;
      if (n == 0) begin
         total++;
         if (dn[d] !== 1'b1 || stp[d] !== 1'b0 || bsy[d] !== 1'b0) begin
            bad++; $display("FAIL step0 d=%0d done=%b step=%b busy=%b exp=100", d, dn[d], stp[d], bsy[d]);
         end
         cyc();
         total++;
         if (dn[d] !== 1'b0 || bsy[d] !== 1'b0 || q[d] !== mq[d]) begin
            bad++; $display("FAIL step0_after d=%0d done=%b busy=%b q=%h exp done=0 busy=0 q=%h", d, dn[d], bsy[d], q[d], mq[d]);
         end
         return;
      end
      for (int c = 1; c <= last + 1; c++) begin
         es = (c > 1) && (((c - 1) % dv) == 0) && (steps < n);
         if (es) begin
            mq[d] = nxt(mq[d]);
            steps++;
         end
         ed = es && (steps == n);
         ee = (inj > 0) && (c == inj + 1);
         total++;
         if (stp[d] !== es || dn[d] !== ed) begin
            bad++; $display("FAIL burst_pulse d=%0d n=%0d c=%0d step=%b done=%b exp step=%b done=%b", d, n, c, stp[d], dn[d], es, ed);
         end
         total++;
         if (q[d] !== mq[d]) begin
            bad++; $display("FAIL burst_q d=%0d n=%0d c=%0d got=%h exp=%h", d, n, c, q[d], mq[d]);
         end
         total++;
         if (cerr[d] !== ee) begin
            bad++; $display("FAIL burst_cmd_err d=%0d c=%0d got=%b exp=%b", d, c, cerr[d], ee);
         end
         if (c < last) begin
            total++;
            if (bsy[d] !== 1'b1) begin
               bad++; $display("FAIL burst_busy d=%0d c=%0d got=%b exp=1", d, c, bsy[d]);
            end
         end else if (c == last + 1) begin
            total++;
            if (bsy[d] !== 1'b0) begin
               bad++; $display("FAIL burst_end_busy d=%0d got=%b exp=0", d, bsy[d]);
            end
         end
         if (c == inj) begin
            cv[d] = 1'b1; cop[d] = 2'd0; carg[d] = 8'h33;
         end
         cyc();
         cv[d] = 1'b0;
      end
   endtask

   // RUN, then STOP issued in run cycle k.
   task automatic do_run_stop(input int d, input int k);
      int dv;
      bit es;
      dv = div_of(d);
      cv[d] = 1'b1; cop[d] = 2'd2; carg[d] = 8'($urandom);
      cyc();
      cv[d] = 1'b0;
      for (int c = 1; c <= k; c++) begin
         es = (c > 1) && (((c - 1) % dv) == 0);
         if (es) mq[d] = nxt(mq[d]);
         total++;
         if (stp[d] !== es || dn[d] !== 1'b0 || bsy[d] !== 1'b1 || cerr[d] !== 1'b0) begin
            bad++; $display("FAIL run_cycle d=%0d c=%0d step=%b done=%b busy=%b err=%b exp step=%b done=0 busy=1 err=0",
                            d, c, stp[d], dn[d], bsy[d], cerr[d], es);
         end
         total++;
         if (q[d] !== mq[d]) begin
            bad++; $display("FAIL run_q d=%0d c=%0d got=%h exp=%h", d, c, q[d], mq[d]);
         end
         if (c == k) begin
            cv[d] = 1'b1; cop[d] = 2'd3;
         end
         cyc();
         cv[d] = 1'b0;
      end
      total++;
      if (stp[d] !== 1'b0 || dn[d] !== 1'b1 || bsy[d] !== 1'b0 || q[d] !== mq[d]) begin
         bad++; $display("FAIL run_stop d=%0d k=%0d step=%b done=%b busy=%b q=%h exp step=0 done=1 busy=0 q=%h",
                         d, k, stp[d], dn[d], bsy[d], q[d], mq[d]);
      end
      cyc();
      total++;
      if (stp[d] !== 1'b0 || dn[d] !== 1'b0 || q[d] !== mq[d]) begin
         bad++; $display("FAIL run_after_stop d=%0d step=%b done=%b q=%h exp step=0 done=0 q=%h", d, stp[d], dn[d], q[d], mq[d]);
      end
   endtask

   task automatic do_idle_stop(input int d);
      cv[d] = 1'b1; cop[d] = 2'd3; carg[d] = 8'($urandom);
      cyc();
      cv[d] = 1'b0;
      total++;
      if (dn[d] !== 1'b1 || bsy[d] !== 1'b0 || stp[d] !== 1'b0 || cerr[d] !== 1'b0) begin
         bad++; $display("FAIL idle_stop d=%0d done=%b busy=%b step=%b err=%b exp 1000", d, dn[d], bsy[d], stp[d], cerr[d]);
      end
      cyc();
      total++;
      if (dn[d] !== 1'b0 || q[d] !== mq[d]) begin
         bad++; $display("FAIL idle_stop_after d=%0d done=%b q=%h exp done=0 q=%h", d, dn[d], q[d], mq[d]);
      end
   endtask

   task automatic test_reset();
      for (int d = 0; d < 2; d++) begin
         total++;
         if (q[d] !== 8'h01 || crdy[d] !== 1'b0 || stp[d] !== 1'b0 || dn[d] !== 1'b0 ||
             bsy[d] !== 1'b0 || serr[d] !== 1'b0 || cerr[d] !== 1'b0) begin
            bad++; $display("FAIL reset_values d=%0d q=%h rdy=%b step=%b done=%b busy=%b serr=%b cerr=%b exp q=01 all 0",
                            d, q[d], crdy[d], stp[d], dn[d], bsy[d], serr[d], cerr[d]);
         end
      end
      rst = 1'b1;
      cyc();
      for (int d = 0; d < 2; d++) begin
         total++;
         if (crdy[d] !== 1'b1 || q[d] !== 8'h01) begin
            bad++; $display("FAIL reset_release d=%0d rdy=%b q=%h exp rdy=1 q=01", d, crdy[d], q[d]);
         end
      end
   endtask

   task automatic test_step5();
      do_load(0, 8'h01);
      do_burst(0, 5, 0);
      total++;
      if (q[0] !== 8'h88) begin
         bad++; $display("FAIL step5_final got=%h exp=88", q[0]);
      end
   endtask

   task automatic test_run_stop();
      do_run_stop(1, 12);
      do_run_stop(0, 6);
   endtask

   task automatic test_seed_err();
      do_load(1, 8'h00);
      do_load(1, 8'h5A);
   endtask

   task automatic test_step_zero();
      do_burst(0, 0, 0);
      do_burst(1, 0, 0);
   endtask

   task automatic test_cmd_err();
      do_burst(1, 10, 7);
      do_burst(0, 10, 3);
      do_idle_stop(0);
      do_idle_stop(1);
   endtask

   task automatic test_long_burst();
      do_load(0, 8'hC3);
      do_burst(0, 255, 0);
   endtask

   task automatic test_reset_midrun();
      cv[0] = 1'b1; cop[0] = 2'd2;
      cyc();
      cv[0] = 1'b0;
      cyc(); cyc(); cyc();
      rst = 1'b0;
      #1;
      total++;
      if (q[0] !== 8'h01 || bsy[0] !== 1'b0 || dn[0] !== 1'b0 || stp[0] !== 1'b0 || q[1] !== 8'h01) begin
         bad++; $display("FAIL midrun_reset q0=%h busy=%b done=%b step=%b q1=%h exp q=01 busy=0 done=0 step=0",
                         q[0], bsy[0], dn[0], stp[0], q[1]);
      end
      cyc();
      rst = 1'b1;
      mq[0] = 8'h01; mq[1] = 8'h01;
      mserr[0] = 1'b0; mserr[1] = 1'b0;
      cyc();
      total++;
      if (dn[0] !== 1'b0 || bsy[0] !== 1'b0 || q[0] !== 8'h01) begin
         bad++; $display("FAIL midrun_after done=%b busy=%b q=%h exp done=0 busy=0 q=01", dn[0], bsy[0], q[0]);
      end
      do_burst(0, 1, 0);
      total++;
      if (q[0] !== 8'h80) begin
         bad++; $display("FAIL midrun_step1 got=%h exp=80", q[0]);
      end
   endtask

   task automatic test_random();
      int d, sel, n, inj;
      for (int i = 0; i < 30; i++) begin
         d = int'($urandom_range(0, 1));
         sel = int'($urandom_range(0, 3));
         case (sel)
            0: begin
               if ($urandom_range(0, 3) == 0) do_load(d, 8'h00);
               else do_load(d, 8'($urandom_range(1, 255)));
            end
            1: begin
               n = int'($urandom_range(0, 12));
               inj = 0;
               if (n > 0 && $urandom_range(0, 1) == 1)
                  inj = int'($urandom_range(1, div_of(d) * n));
               do_burst(d, n, inj);
            end
            2: do_run_stop(d, int'($urandom_range(1, 14)));
            default: do_idle_stop(d);
         endcase
         total++;
         if (serr[d] !== mserr[d]) begin
            bad++; $display("FAIL random_seed_err d=%0d i=%0d got=%b exp=%b", d, i, serr[d], mserr[d]);
         end
      end
   endtask

   initial begin
      rst = 1'b0;
      for (int d = 0; d < 2; d++) begin
         cv[d] = 1'b0; cop[d] = 2'd0; carg[d] = 8'h00;
         mq[d] = 8'h01; mserr[d] = 1'b0;
      end
      cyc();
      cyc();
      test_reset();
      test_step5();
      test_run_stop();
      test_seed_err();
      test_step_zero();
      test_cmd_err();
      test_long_burst();
      test_reset_midrun();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
